// File: rtl/fixedpoint_issue_sched_pkg.sv
// Shared types and helpers for the fixed-point execute-stage issue/writeback scheduler.
package fixedpoint_issue_sched_pkg;

  typedef enum logic [2:0] {
    UNIT_ALU   = 3'd0,
    UNIT_ROTM  = 3'd1,
    UNIT_SPREU = 3'd2,
    UNIT_MUL   = 3'd3,
    UNIT_DIV   = 3'd4
  } fxdpt_unit_e;

  typedef logic [4:0] reg_index_t;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_COUNT = 2'd1,
    DIV_HOLD  = 2'd2
  } div_state_e;

  function automatic logic [31:0] dest_onehot(input reg_index_t idx);
    dest_onehot = 32'd1 << idx;
  endfunction

  function automatic logic is_single_cycle(input logic [2:0] unit);
    is_single_cycle = (unit == UNIT_ALU) || (unit == UNIT_ROTM) || (unit == UNIT_SPREU);
  endfunction

endpackage

// File: rtl/fixedpoint_issue_sched_chk.sv
// Invariant checker: at most one source may claim the writeback register per cycle.
module fixedpoint_issue_sched_chk (
  input logic clk,
  input logic reset,
  input logic mul_due_next,
  input logic div_wb,
  input logic fire_single
);

  one_wb_source: assert property (@(posedge clk) disable iff (reset)
    $onehot0({mul_due_next, div_wb, fire_single}));

endmodule

// File: rtl/fixedpoint_issue_sched_div_seq.sv
// Divider sequencer: counts DIV_CYCLES after start, then holds the result until the
// writeback port is free of a due multiplier result.
module fixedpoint_div_seq
  import fixedpoint_issue_sched_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       start,
  input  reg_index_t start_dest,
  input  logic       mul_due_next,
  output logic       div_start,
  output logic       div_pending,
  output logic       div_busy,
  output logic       div_abort,
  output logic       div_wb,
  output reg_index_t div_dest
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  div_state_e    state, state_next;
  logic [CW-1:0] count, count_next;

  // In HOLD, count==1 means the result still waits for a slot, count==0 means it is being written.
  assign div_start   = start;
  assign div_busy    = (state != DIV_IDLE);
  assign div_pending = ((state == DIV_COUNT) && (count == CW'(1))) ||
                       ((state == DIV_HOLD) && (count != {CW{1'b0}}));

  // State, counter, abort pulse and captured destination.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DIV_IDLE;
      count     <= {CW{1'b0}};
      div_abort <= 1'b0;
      div_dest  <= 5'd0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      div_abort <= flush && (state != DIV_IDLE);
      if (start) begin
        div_dest <= start_dest;
      end
    end
  end

  // Next-state and writeback-claim decode.
  always_comb begin
    state_next = state;
    count_next = count;
    div_wb     = 1'b0;
    if (flush) begin
      state_next = DIV_IDLE;
      count_next = {CW{1'b0}};
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            state_next = DIV_COUNT;
            count_next = CW'(DIV_CYCLES);
          end else begin
            state_next = DIV_IDLE;
          end
        end
        DIV_COUNT: begin
          if (count == CW'(1)) begin
            state_next = DIV_HOLD;
            div_wb     = !mul_due_next;
            count_next = mul_due_next ? CW'(1) : {CW{1'b0}};
          end else begin
            count_next = count - CW'(1);
          end
        end
        DIV_HOLD: begin
          if (count == {CW{1'b0}}) begin
            state_next = DIV_IDLE;
          end else if (!mul_due_next) begin
            div_wb     = 1'b1;
            count_next = {CW{1'b0}};
          end else begin
            count_next = count;
          end
        end
        default: begin
          state_next = DIV_IDLE;
          count_next = {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/fixedpoint_issue_sched.sv
// Issue/writeback scheduler for the fixed-point execute stage: one op in, one result out
// per cycle, with multiplier pipe tracking, divider sequencing and in-flight dest mask.
module fixedpoint_issue_sched
  import fixedpoint_issue_sched_pkg::*;
#(
  parameter int MUL_STAGES = 3,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [2:0]  issue_unit,
  input  logic [4:0]  issue_dest,
  output logic        issue_ready,
  input  logic        flush,
  output logic        div_start,
  output logic        div_abort,
  output logic        div_busy,
  output logic        wb_valid,
  output logic [2:0]  wb_unit,
  output logic [4:0]  wb_dest,
  output logic [31:0] inflight_mask
);

  // The wb register is the final multiplier stage, so the tracking pipe is one shorter.
  localparam int MUL_DEPTH = MUL_STAGES - 1;

  logic [MUL_DEPTH-1:0] mul_valid;
  reg_index_t           mul_dest [MUL_DEPTH];
  logic                 mul_due_next;
  logic                 fire, fire_single, fire_mul, fire_div;
  logic                 div_pending, div_wb;
  reg_index_t           div_dest;
  logic [31:0]          mask_set, mask_clr;

  assign mul_due_next = mul_valid[MUL_DEPTH-1];
  assign fire         = issue_valid && issue_ready;
  assign fire_single  = fire && is_single_cycle(issue_unit);
  assign fire_mul     = fire && (issue_unit == UNIT_MUL);
  assign fire_div     = fire && (issue_unit == UNIT_DIV);

  // Issue acceptance; unit codes above DIV are never accepted.
  always_comb begin
    issue_ready = 1'b0;
    if (reset || flush || div_pending || (issue_unit > 3'd4)) begin
      issue_ready = 1'b0;
    end else if (is_single_cycle(issue_unit)) begin
      issue_ready = !mul_due_next;
    end else if (issue_unit == UNIT_DIV) begin
      issue_ready = !div_busy;
    end else begin
      issue_ready = 1'b1;
    end
  end

  // Multiplier valid bits shift every cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mul_valid <= {MUL_DEPTH{1'b0}};
    end else begin
      for (int i = MUL_DEPTH - 1; i > 0; i--) begin
        mul_valid[i] <= mul_valid[i-1];
      end
      mul_valid[0] <= fire_mul;
    end
  end

  // Multiplier destinations follow their valid bits.
  always_ff @(posedge clk) begin
    for (int i = MUL_DEPTH - 1; i > 0; i--) begin
      mul_dest[i] <= mul_dest[i-1];
    end
    mul_dest[0] <= issue_dest;
  end

  // Writeback register: a due multiplier outranks the divider, which outranks new single-cycle ops.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wb_valid <= 1'b0;
      wb_unit  <= 3'd0;
      wb_dest  <= 5'd0;
    end else if (mul_due_next) begin
      wb_valid <= 1'b1;
      wb_unit  <= UNIT_MUL;
      wb_dest  <= mul_dest[MUL_DEPTH-1];
    end else if (div_wb) begin
      wb_valid <= 1'b1;
      wb_unit  <= UNIT_DIV;
      wb_dest  <= div_dest;
    end else if (fire_single) begin
      wb_valid <= 1'b1;
      wb_unit  <= issue_unit;
      wb_dest  <= issue_dest;
    end else begin
      wb_valid <= 1'b0;
      wb_unit  <= 3'd0;
      wb_dest  <= 5'd0;
    end
  end

  // In-flight mask updates; a new issue to the same index wins over a retiring one.
  always_comb begin
    mask_set = (fire_mul || fire_div) ? dest_onehot(issue_dest) : 32'd0;
    if (wb_valid && ((wb_unit == UNIT_MUL) || (wb_unit == UNIT_DIV))) begin
      mask_clr = dest_onehot(wb_dest);
    end else begin
      mask_clr = 32'd0;
    end
  end

  // In-flight mask register.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      inflight_mask <= 32'd0;
    end else begin
      inflight_mask <= (inflight_mask & ~mask_clr) | mask_set;
    end
  end

  fixedpoint_div_seq #(.DIV_CYCLES(DIV_CYCLES)) u_div_seq (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .start        (fire_div),
    .start_dest   (issue_dest),
    .mul_due_next (mul_due_next),
    .div_start    (div_start),
    .div_pending  (div_pending),
    .div_busy     (div_busy),
    .div_abort    (div_abort),
    .div_wb       (div_wb),
    .div_dest     (div_dest)
  );

  fixedpoint_issue_sched_chk u_chk (
    .clk          (clk),
    .reset        (reset),
    .mul_due_next (mul_due_next),
    .div_wb       (div_wb),
    .fire_single  (fire_single)
  );

endmodule
